// File: rtl/nback_pkg.sv
// ============================================================================
// nback_pkg
// Shared types and constants for the n-back autoplayer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package nback_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SYM = 2'd1,
        DELAY    = 2'd2,
        PRESS    = 2'd3
    } nback_ap_state_t;

    // Symbol value shown on the LEDs during a pause
    localparam int unsigned SYMBOL_BLANK = 0;

endpackage

`default_nettype wire

// File: rtl/nback_history.sv
// ============================================================================
// nback_history
// Last-N symbol shift register with a saturating count of valid entries.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module nback_history #(
    parameter int N        = 3,
    parameter int SYMBOL_W = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clr_i,
    input  logic                push_i,
    input  logic [SYMBOL_W-1:0] sym_i,
    output logic [SYMBOL_W-1:0] nback_sym_o,
    output logic                full_o
);

    localparam int VALID_W = $clog2(N + 1);

    logic [SYMBOL_W-1:0] hist_q [N];
    logic [SYMBOL_W-1:0] hist_d [N];
    logic [VALID_W-1:0]  valid_q;
    logic [VALID_W-1:0]  valid_d;

    always_comb begin
        hist_d  = hist_q;
        valid_d = valid_q;
        if (clr_i) begin
            valid_d = '0;
            for (int i = 0; i < N; i++) hist_d[i] = '0;
        end else if (push_i) begin
            hist_d[0] = sym_i;
            for (int i = 1; i < N; i++) hist_d[i] = hist_q[i-1];
            if (valid_q != VALID_W'(N)) valid_d = valid_q + VALID_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int i = 0; i < N; i++) hist_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            hist_q  <= hist_d;
        end
    end

    assign nback_sym_o = hist_q[N-1];
    assign full_o      = (valid_q == VALID_W'(N));

endmodule

`default_nettype wire

// File: rtl/nback_autoplayer.sv
// ============================================================================
// nback_autoplayer
// Automated n-back player: detects N-back matches and issues a timed answer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module nback_autoplayer
    import nback_pkg::*;
#(
    parameter int N              = 3,
    parameter int SYMBOL_W       = 8,
    parameter int REACTION_TICKS = 5000000,
    parameter int ANSWER_TICKS   = 2500000,
    parameter int CNT_W          = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                enable_i,
    input  logic [SYMBOL_W-1:0] current_symbol_i,
    input  logic                user_in_game_i,
    output logic                answer_o,
    output logic                busy_o,
    output logic [CNT_W-1:0]    match_cnt_o,
    output logic [CNT_W-1:0]    answer_cnt_o
);

    localparam int TICK_MAX = (REACTION_TICKS > ANSWER_TICKS) ? REACTION_TICKS : ANSWER_TICKS;
    localparam int TICK_W   = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
    localparam logic [TICK_W-1:0]   REACT_LOAD  = TICK_W'(REACTION_TICKS - 1);
    localparam logic [TICK_W-1:0]   ANSWER_LOAD = TICK_W'(ANSWER_TICKS - 1);
    localparam logic [CNT_W-1:0]    CNT_MAX     = '1;
    localparam logic [SYMBOL_W-1:0] BLANK       = SYMBOL_W'(SYMBOL_BLANK);

    nback_ap_state_t     state_q, state_d;
    logic [SYMBOL_W-1:0] prev_sym_q, prev_sym_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [CNT_W-1:0]    match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0]    answer_cnt_q, answer_cnt_d;
    logic                answer_q, answer_d;
    logic                busy_q, busy_d;

    logic                onset;
    logic                blank;
    logic                is_match;
    logic                hist_clr;
    logic [SYMBOL_W-1:0] nback_sym;
    logic                hist_full;

    assign blank    = (current_symbol_i == BLANK);
    assign onset    = !blank && (prev_sym_q == BLANK);
    assign is_match = onset && hist_full && (current_symbol_i == nback_sym);
    // History only accumulates while a round is actually being played
    assign hist_clr = !user_in_game_i || (state_q == IDLE);

    nback_history #(
        .N        (N),
        .SYMBOL_W (SYMBOL_W)
    ) u_history (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (hist_clr),
        .push_i      (onset),
        .sym_i       (current_symbol_i),
        .nback_sym_o (nback_sym),
        .full_o      (hist_full)
    );

    always_comb begin
        state_d      = state_q;
        tick_d       = tick_q;
        match_cnt_d  = match_cnt_q;
        answer_cnt_d = answer_cnt_q;
        prev_sym_d   = current_symbol_i;

        if (!user_in_game_i) begin
            state_d = IDLE;
            tick_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d      = WAIT_SYM;
                    match_cnt_d  = '0;
                    answer_cnt_d = '0;
                end
                WAIT_SYM: begin
                    if (is_match) begin
                        if (match_cnt_q != CNT_MAX) match_cnt_d = match_cnt_q + CNT_W'(1);
                        if (enable_i) begin
                            state_d = DELAY;
                            tick_d  = REACT_LOAD;
                        end
                    end
                end
                DELAY: begin
                    // A blank or a disable abandons the pending answer, even on the last tick
                    if (blank || !enable_i) begin
                        state_d = WAIT_SYM;
                    end else if (tick_q == '0) begin
                        state_d = PRESS;
                        tick_d  = ANSWER_LOAD;
                        if (answer_cnt_q != CNT_MAX) answer_cnt_d = answer_cnt_q + CNT_W'(1);
                    end else begin
                        tick_d = tick_q - TICK_W'(1);
                    end
                end
                PRESS: begin
                    if (tick_q == '0) state_d = WAIT_SYM;
                    else              tick_d  = tick_q - TICK_W'(1);
                end
                default: state_d = IDLE;
            endcase
        end

        answer_d = (state_d == PRESS);
        busy_d   = (state_d == DELAY) || (state_d == PRESS);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            prev_sym_q   <= '0;
            tick_q       <= '0;
            match_cnt_q  <= '0;
            answer_cnt_q <= '0;
            answer_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_sym_q   <= prev_sym_d;
            tick_q       <= tick_d;
            match_cnt_q  <= match_cnt_d;
            answer_cnt_q <= answer_cnt_d;
            answer_q     <= answer_d;
            busy_q       <= busy_d;
        end
    end

    assign answer_o     = answer_q;
    assign busy_o       = busy_q;
    assign match_cnt_o  = match_cnt_q;
    assign answer_cnt_o = answer_cnt_q;

endmodule

`default_nettype wire
